// File: rtl/rr_sel_arbiter_4_if.sv
// Handshake bundle between the four packet sources, the round-robin
// select generator, and the downstream consumer of the 4:1 mux output.
interface rr_sel_arbiter_4_if;
  logic [3:0] in_valid;
  logic [3:0] in_last;
  logic [3:0] in_ready;
  logic [1:0] sel;
  logic       out_valid;
  logic       out_last;
  logic       out_ready;
  logic       trunc;

  // Environment side: sources plus consumer.
  modport master (
    output in_valid, in_last, out_ready,
    input  in_ready, sel, out_valid, out_last, trunc
  );

  // Arbiter side.
  modport slave (
    input  in_valid, in_last, out_ready,
    output in_ready, sel, out_valid, out_last, trunc
  );
endinterface

// File: rtl/rr_sel_arbiter_4.sv
// Round-robin select generator for a 4:1 packet mux. A grant is held for a
// whole packet (or until MAX_BEATS forces an end), then priority rotates to
// the source after the one just served.
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | no grant; picks the next winner from ptr onward, one bubble cycle
// LOCKED | sel frozen on the granted source until its last beat transfers
module rr_sel_arbiter_4 #(
  parameter int MAX_BEATS = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  rr_sel_arbiter_4_if.slave bus
);

  localparam int CW = $clog2(MAX_BEATS + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(MAX_BEATS - 1);

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [1:0]    sel_q;
  logic [1:0]    ptr;
  logic [1:0]    winner;
  logic          any_req;
  logic [CW-1:0] beat_cnt;
  logic          trunc_q;

  logic [3:0]    in_ready_c;
  logic          out_valid_c;
  logic          out_last_c;
  logic          xfer;

  // Rotating-priority scan: first requesting source at or after ptr.
  always_comb begin
    logic [1:0] idx;
    winner  = ptr;
    any_req = 1'b0;
    idx     = ptr;
    for (int k = 0; k < 4; k++) begin
      idx = ptr + 2'(k);
      if (!any_req && bus.in_valid[idx]) begin
        winner  = idx;
        any_req = 1'b1;
      end
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state: lock on any request, release on the transfer of the last beat.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_req)           state_nxt = LOCKED;
      LOCKED:  if (xfer && out_last_c) state_nxt = IDLE;
      default:                         state_nxt = IDLE;
    endcase
  end

  // Outputs: only the granted source sees ready; other sources are ignored.
  always_comb begin
    in_ready_c  = 4'b0000;
    out_valid_c = 1'b0;
    out_last_c  = 1'b0;
    if (state == LOCKED) begin
      out_valid_c       = bus.in_valid[sel_q];
      in_ready_c[sel_q] = bus.out_ready;
      out_last_c        = bus.in_valid[sel_q] &
                          (bus.in_last[sel_q] | (beat_cnt == LAST_CNT));
    end
    xfer = out_valid_c & bus.out_ready;
  end

  // Grant, priority pointer, beat counter and truncation pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_q    <= 2'd0;
      ptr      <= 2'd0;
      beat_cnt <= '0;
      trunc_q  <= 1'b0;
    end else begin
      trunc_q <= 1'b0;
      if (state == IDLE) begin
        if (any_req) begin
          sel_q    <= winner;
          beat_cnt <= '0;
        end
      end else if (xfer) begin
        if (out_last_c) begin
          ptr      <= sel_q + 2'd1;
          beat_cnt <= '0;
          // Forced end: the source did not mark this beat as last.
          trunc_q  <= ~bus.in_last[sel_q];
        end else begin
          beat_cnt <= beat_cnt + CW'(1);
        end
      end
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_c;
  assign bus.out_last  = out_last_c;
  assign bus.sel       = sel_q;
  assign bus.trunc     = trunc_q;

endmodule
